// File: rtl/change_dispenser_if.sv
// Request/coin-mechanism signal bundle for change_dispenser.
// The slave modport is the dispenser; the master is the host/mechanism side.
interface change_dispenser_if;
    logic       start;
    logic [5:0] change_amt;
    logic [4:0] bank;
    logic       eject_ack;
    logic [4:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic       done;
    logic       shortfall;
    logic       fault;
    logic [5:0] remaining;

    modport master (
        output start, change_amt, bank, eject_ack,
        input  coin_out, coin_valid, busy, done, shortfall, fault, remaining
    );

    modport slave (
        input  start, change_amt, bank, eject_ack,
        output coin_out, coin_valid, busy, done, shortfall, fault, remaining
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin change dispenser: pays out an amount in nickels one coin at a time,
// largest available coin first, with an eject-ack timeout.
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);
    localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StSelect, StEject, StDone, StError} state_e;

    state_e          state_q, state_d;
    logic [5:0]      remaining_q, remaining_d;
    logic [4:0]      coin_q, coin_d;
    logic            shortfall_q, shortfall_d;
    logic            fault_q, fault_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      pick;

    function automatic logic [5:0] coin_value(input logic [4:0] c);
        case (c)
            5'b10000: coin_value = 6'd20;
            5'b01000: coin_value = 6'd10;
            5'b00100: coin_value = 6'd5;
            5'b00010: coin_value = 6'd2;
            5'b00001: coin_value = 6'd1;
            default:  coin_value = 6'd0;
        endcase
    endfunction

    // Largest stocked coin that does not exceed what is still owed.
    always_comb begin
        pick = 5'b00000;
        if (bus.bank[4] && remaining_q >= 6'd20)      pick = 5'b10000;
        else if (bus.bank[3] && remaining_q >= 6'd10) pick = 5'b01000;
        else if (bus.bank[2] && remaining_q >= 6'd5)  pick = 5'b00100;
        else if (bus.bank[1] && remaining_q >= 6'd2)  pick = 5'b00010;
        else if (bus.bank[0] && remaining_q >= 6'd1)  pick = 5'b00001;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = coin_q;
        shortfall_d = shortfall_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    remaining_d = bus.change_amt;
                    shortfall_d = 1'b0;
                    fault_d     = 1'b0;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                if (remaining_q == 6'd0) begin
                    state_d = StDone;
                end else if (pick != 5'b00000) begin
                    coin_d  = pick;
                    cnt_d   = '0;
                    state_d = StEject;
                end else begin
                    shortfall_d = 1'b1;
                    state_d     = StError;
                end
            end
            StEject: begin
                if (bus.eject_ack) begin
                    remaining_d = remaining_q - coin_value(coin_q);
                    state_d     = StSelect;
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone, StError: state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= 6'd0;
            coin_q      <= 5'b00000;
            shortfall_q <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            shortfall_q <= shortfall_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.coin_valid = (state_q == StEject);
    assign bus.coin_out   = (state_q == StEject) ? coin_q : 5'b00000;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone) || (state_q == StError);
    assign bus.shortfall  = shortfall_q;
    assign bus.fault      = fault_q;
    assign bus.remaining  = remaining_q;
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 8, max cycles coin_valid may wait for eject_ack before fault.
REQ-002 SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to pay out change_amt; honoured only in IDLE.
REQ-005 SHALL have port change_amt  input  6  change owed, in nickels (0..63 = $0.00..$3.15).
REQ-006 SHALL have port bank  input  5  coin availability: bit4 dollar, bit3 half, bit2 quarter, bit1 dime, bit0 nickel.
REQ-007 SHALL have port eject_ack  input  1  coin mechanism has released the presented coin.
REQ-008 SHALL have port coin_out  output  5  one-hot coin to eject, same bit order as bank; 0 when not valid.
REQ-009 SHALL have port coin_valid  output  1  coin_out is presented to the mechanism.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse at end of every accepted request.
REQ-012 SHALL have port shortfall  output  1  request ended with remaining > 0 because no coin fit.
REQ-013 SHALL have port fault  output  1  request ended on eject_ack timeout.
REQ-014 SHALL have port remaining  output  6  nickels still owed for the current/last request.

Function
REQ-015 SHALL implement states IDLE, SELECT, EJECT, DONE, ERROR.
REQ-016 IDLE: on start, latch change_amt into remaining, clear shortfall and fault, go SELECT next cycle.
REQ-017 start while busy SHALL be ignored; change_amt not re-sampled.
REQ-018 SELECT (one cycle): remaining = 0 -> DONE; else choose largest coin with bank bit set and value <= remaining (dollar 20, half 10, quarter 5, dime 2, nickel 1), register it, go EJECT; none fits -> ERROR with shortfall=1.
REQ-019 bank SHALL be sampled fresh in every SELECT cycle (inventory may drain mid-request).
REQ-020 EJECT: coin_valid=1 and coin_out stable until eject_ack; on ack cycle subtract coin value from remaining (registered), drop coin_valid, go SELECT.
REQ-021 coin_valid SHALL never be high for two consecutive requests without an intervening SELECT cycle.
REQ-022 EJECT wait counter SHALL reset on EJECT entry; if ACK_TIMEOUT cycles elapse without ack -> ERROR, fault=1, coin_valid=0, remaining unchanged.
REQ-023 eject_ack outside EJECT SHALL be ignored.
REQ-024 remaining arithmetic SHALL never underflow; selected coin value is always <= remaining.
REQ-025 DONE: done=1 one cycle, then IDLE; ERROR: done=1 one cycle, then IDLE, shortfall/fault held until next accepted start.
REQ-026 change_amt = 0 SHALL complete as IDLE->SELECT->DONE with no coin ejected, done 2 cycles after start.
REQ-027 latency start -> first coin_valid SHALL be 2 cycles.

Reset
REQ-028 reset SHALL override all inputs in the cycle sampled, including mid-EJECT.
REQ-029 after reset: state IDLE, coin_out=0, coin_valid=0, busy=0, done=0, shortfall=0, fault=0, remaining=0, timeout counter=0.
REQ-030 a request interrupted by reset SHALL be abandoned; no done pulse.

Verification
REQ-031 change_amt=15, bank=11111, ack 1 cycle after each valid -> half then quarter ejected, remaining 15->5->0, done, shortfall=0.
REQ-032 change_amt=15, bank=10111 -> quarter x3; bank=00101 with change_amt=3 -> nickel x3 (dime unavailable).
REQ-033 change_amt=3, bank=00100 -> no coin, ERROR, shortfall=1, remaining=3, done pulse.
REQ-034 change_amt=20, bank=11111, eject_ack never asserted -> coin_out=10000 held 8 cycles, then fault=1, remaining=20, done pulse.
REQ-035 change_amt=30, reset asserted during first EJECT -> next cycle IDLE, all outputs at reset values, no done.
REQ-036 start pulsed again while busy with change_amt=7 -> ignored; original request completes with its own amount.
